// File: rtl/i2c_pkg.sv
// i2c_pkg: FSM state codes and bus-level constants shared by the I2C target and master.
package i2c_pkg;
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] ADDR     = 3'd1;
   localparam logic [2:0] ADDR_ACK = 3'd2;
   localparam logic [2:0] RX_DATA  = 3'd3;
   localparam logic [2:0] RX_ACK   = 3'd4;
   localparam logic [2:0] TX_DATA  = 3'd5;
   localparam logic [2:0] TX_ACK   = 3'd6;
   localparam logic I2C_ACK      = 1'b0;
   localparam logic I2C_NACK     = 1'b1;
   localparam logic I2C_RW_READ  = 1'b1;
   localparam logic I2C_RW_WRITE = 1'b0;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: per-line synchronizer with level/rise/fall outputs.
// I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample stability filter after the synchronizer.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync;
   logic prev;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [1:0] hist;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) hist <= 2'b11;
      else hist <= {hist[0], sync[SYNC_STAGES-1]};
   // the line only moves once three consecutive synchronized samples agree
   assign level = (sync[SYNC_STAGES-1] == hist[0] && hist[0] == hist[1]) ? hist[0] : prev;
`else
   assign level = sync[SYNC_STAGES-1];
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync <= '1;
         prev <= 1'b1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         prev <= level;
      end
   assign rise = level & ~prev;
   assign fall = ~level & prev;
endmodule

// File: rtl/i2c_slave_controller.sv
// i2c_slave_controller: 7-bit-address I2C target; SCL/SDA are oversampled on clk and
// ACKs / read data are driven open-drain on SDA (glitch filter: I2C_SLAVE_GLITCH_FILTER_EN).
module i2c_slave_controller
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_req,
   output logic       busy
);
   logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
   logic start, stop, full, sda_low;
   logic [2:0] state, cnt;
   logic [7:0] shift;
   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
      .clk(clk), .rst_n(rst_n), .din(i2c_scl), .level(scl), .rise(scl_rise), .fall(scl_fall)
   );
   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
      .clk(clk), .rst_n(rst_n), .din(i2c_sda), .level(sda), .rise(sda_rise), .fall(sda_fall)
   );
   assign start   = scl & sda_fall;
   assign stop    = scl & sda_rise;
   assign i2c_sda = sda_low ? 1'b0 : 1'bz;
   // full marks that the 8th bit of the current byte has been clocked in/out
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 3'd7;
         shift    <= 8'd0;
         full     <= 1'b0;
         sda_low  <= 1'b0;
         rx_data  <= 8'd0;
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         if (start) begin
            state   <= ADDR;
            cnt     <= 3'd7;
            full    <= 1'b0;
            sda_low <= 1'b0;
         end else if (stop) begin
            state   <= IDLE;
            sda_low <= 1'b0;
            busy    <= 1'b0;
         end else if (scl_rise) begin
            case (state)
               ADDR, RX_DATA: begin
                  shift <= {shift[6:0], sda};
                  cnt   <= cnt - 3'd1;
                  full  <= cnt == 3'd0;
                  if (cnt == 3'd0 && state == RX_DATA) begin
                     rx_data  <= {shift[6:0], sda};
                     rx_valid <= 1'b1;
                  end
                  if (cnt == 3'd0 && state == ADDR && shift[6:0] == SLAVE_ADDR && sda == I2C_RW_READ)
                     tx_req <= 1'b1;
               end
               TX_DATA: begin
                  cnt  <= cnt - 3'd1;
                  full <= cnt == 3'd0;
               end
               TX_ACK:
                  if (sda == I2C_NACK) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else tx_req <= 1'b1;
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state)
               ADDR:
                  if (full) begin
                     full <= 1'b0;
                     if (shift[7:1] == SLAVE_ADDR) begin
                        sda_low <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ADDR_ACK;
                     end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end
                  end
               ADDR_ACK:
                  if (shift[0] == I2C_RW_WRITE) begin
                     sda_low <= 1'b0;
                     state   <= RX_DATA;
                  end else begin
                     shift   <= tx_data;
                     sda_low <= ~tx_data[7];
                     state   <= TX_DATA;
                  end
               RX_DATA:
                  if (full) begin
                     full    <= 1'b0;
                     sda_low <= 1'b1;
                     state   <= RX_ACK;
                  end
               RX_ACK: begin
                  sda_low <= 1'b0;
                  cnt     <= 3'd7;
                  state   <= RX_DATA;
               end
               TX_DATA:
                  if (full) begin
                     full    <= 1'b0;
                     sda_low <= 1'b0;
                     state   <= TX_ACK;
                  end else begin
                     sda_low <= ~shift[6];
                     shift   <= {shift[6:0], 1'b0};
                  end
               TX_ACK: begin
                  shift   <= tx_data;
                  sda_low <= ~tx_data[7];
                  state   <= TX_DATA;
               end
               default: ;
            endcase
         end
      end
endmodule

// File: tb/tb_i2c_slave_controller.sv
// tb_i2c_slave_controller: bit-level I2C master driving the target, with a transaction-level
// expectation model (rx queue, tx_req counts, latency) checked every cycle.
module tb_i2c_slave_controller;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   localparam int LAT = 5;
   localparam logic [7:0] GLITCH_RX = 8'hA5;
   localparam logic GLITCH_ACK = 1'b0;
`else
   localparam int LAT = 3;
   localparam logic [7:0] GLITCH_RX = 8'hD2;
   localparam logic GLITCH_ACK = 1'b1;
`endif
   logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_low = 1'b0;
   logic [7:0] tx_data = 8'd0;
   logic [7:0] rx_data;
   logic rx_valid, tx_req, busy;
   wire sda;
   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);
   int total = 0, bad = 0, n_rx = 0, n_tx = 0, since_rise = 0;
   logic quiet = 1'b0, scl_q = 1'b1, rxv_q = 1'b0, txr_q = 1'b0;
   logic [7:0] exp_rx_last = 8'd0;
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   logic slave_drv;
   assign slave_drv = (sda == 1'b0) && !m_low;

   i2c_slave_controller dut (
      .clk(clk), .rst_n(rst_n), .i2c_scl(scl), .i2c_sda(sda), .tx_data(tx_data),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // clocks since the last SCL rising edge, counted at posedges
   always @(posedge clk) begin
      since_rise = (scl && !scl_q) ? 1 : since_rise + 1;
      scl_q = scl;
   end

   initial forever begin
      @(negedge clk);
      if (tx_req) begin
         if (txq.size() != 0) tx_data = txq.pop_front();
         else tx_data = 8'hEE;
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (rx_valid) begin
            chk("rx_valid single pulse", rxv_q, 0);
            if (rxq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rx_unexpected: rx_valid with data %0h, none expected", rx_data);
            end else begin
               exp_rx_last = rxq.pop_front();
               chk("rx_valid latency", since_rise, LAT);
               n_rx++;
            end
         end
         chk("rx_data", rx_data, exp_rx_last);
         if (tx_req) begin
            chk("tx_req single pulse", txr_q, 0);
            chk("tx_req latency", since_rise, LAT);
            n_tx++;
         end
         if (quiet) begin
            chk("quiet busy", busy, 0);
            chk("quiet sda driven", slave_drv, 0);
         end
      end
      rxv_q = rx_valid;
      txr_q = tx_req;
   end

   task automatic start_c;
      m_low = 1'b0; tick(4);
      scl = 1'b1;   tick(4);
      m_low = 1'b1; tick(4);
      scl = 1'b0;   tick(4);
   endtask

   task automatic stop_c;
      m_low = 1'b1; tick(4);
      scl = 1'b1;   tick(4);
      m_low = 1'b0; tick(8);
   endtask

   task automatic bit_c(input logic b, output logic r);
      m_low = !b; tick(4);
      scl = 1'b1; tick(4);
      r = sda;    tick(4);
      scl = 1'b0; tick(4);
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_c(b[i], r);
         chk("wr bit on bus", r, b[i]);
      end
      bit_c(1'b1, ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] v);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_c(1'b1, r);
         v[i] = r;
      end
      bit_c(nack, r);
      if (nack) chk("rd ack slot released", r, 1);
   endtask

   initial begin
      logic a, r;
      logic [7:0] v, g;
      tick(3);
      chk("reset rx_data", rx_data, 0);
      chk("reset rx_valid", rx_valid, 0);
      chk("reset tx_req", tx_req, 0);
      chk("reset busy", busy, 0);
      chk("reset sda", slave_drv, 0);
      rst_n = 1'b1;
      tick(4);
      // single-byte write
      rxq.push_back(8'h3C);
      start_c;
      wr_byte(8'hA0, a); chk("write addr ack", a, 0);
      chk("busy after addr", busy, 1);
      wr_byte(8'h3C, a); chk("write data ack", a, 0);
      stop_c;
      chk("busy after stop", busy, 0);
      chk("write rx_data", rx_data, 8'h3C);
      chk("write rx count", n_rx, 1);
      // single-byte read, master NACK
      txq.push_back(8'h96);
      start_c;
      wr_byte(8'hA1, a); chk("read addr ack", a, 0);
      chk("read tx_req count", n_tx, 1);
      rd_byte(1'b1, v);  chk("read byte", v, 8'h96);
      chk("busy after nack", busy, 0);
      stop_c;
      // address mismatch
      quiet = 1'b1;
      start_c;
      wr_byte(8'hA2, a); chk("mismatch addr ack", a, 1);
      wr_byte(8'h55, a); chk("mismatch data ack", a, 1);
      stop_c;
      quiet = 1'b0;
      chk("mismatch rx count", n_rx, 1);
      chk("mismatch tx count", n_tx, 1);
      // multi-byte write, repeated START, two-byte read
      rxq.push_back(8'h11); rxq.push_back(8'h22);
      txq.push_back(8'h5A); txq.push_back(8'hC3);
      start_c;
      wr_byte(8'hA0, a); chk("multi addr ack", a, 0);
      wr_byte(8'h11, a); chk("multi d0 ack", a, 0);
      wr_byte(8'h22, a); chk("multi d1 ack", a, 0);
      start_c;
      wr_byte(8'hA1, a); chk("rstart addr ack", a, 0);
      chk("busy after rstart", busy, 1);
      rd_byte(1'b0, v);  chk("read byte 0", v, 8'h5A);
      rd_byte(1'b1, v);  chk("read byte 1", v, 8'hC3);
      chk("busy after multi nack", busy, 0);
      stop_c;
      chk("multi rx count", n_rx, 3);
      chk("multi tx count", n_tx, 3);
      chk("multi rx_data", rx_data, 8'h22);
      // reset after 4 data bits of a write
      start_c;
      wr_byte(8'hA0, a); chk("rst addr ack", a, 0);
      for (int i = 0; i < 4; i++) bit_c(1'b1, r);
      @(posedge clk); #2;
      rst_n = 1'b0; m_low = 1'b0; scl = 1'b1; exp_rx_last = 8'd0;
      #1;
      chk("midreset sda", slave_drv, 0);
      chk("midreset rx_data", rx_data, 0);
      chk("midreset rx_valid", rx_valid, 0);
      chk("midreset tx_req", tx_req, 0);
      chk("midreset busy", busy, 0);
      tick(3);
      rst_n = 1'b1;
      tick(4);
      rxq.push_back(8'h7E);
      start_c;
      wr_byte(8'hA0, a); chk("post-reset addr ack", a, 0);
      wr_byte(8'h7E, a); chk("post-reset data ack", a, 0);
      stop_c;
      chk("post-reset rx_data", rx_data, 8'h7E);
      chk("post-reset rx count", n_rx, 4);
      // 1-clk low glitch on SCL during the MSB of a data byte
      rxq.push_back(GLITCH_RX);
      g = 8'hA5;
      start_c;
      wr_byte(8'hA0, a); chk("glitch addr ack", a, 0);
      for (int i = 7; i >= 0; i--) begin
         m_low = !g[i]; tick(4);
         scl = 1'b1;    tick(2);
         if (i == 7) begin
            scl = 1'b0; tick(1);
            scl = 1'b1; tick(5);
         end else tick(6);
         scl = 1'b0;    tick(4);
      end
      bit_c(1'b1, a); chk("glitch data ack", a, GLITCH_ACK);
      stop_c;
      chk("glitch rx_data", rx_data, GLITCH_RX);
      chk("glitch rx count", n_rx, 5);
      chk("final tx count", n_tx, 3);
      chk("final busy", busy, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
